cpu_fetch: RTL and testbench

CPU_FETCH -- requirements
Module: cpu_fetch

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_prog_mem.sv | 26 ++
 rtl/cpu_fetch.sv | 166 ++++++++++++++++
 tb/tb_cpu_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the instruction fetch block.
package cpu_pkg;

  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_AW    = 4;
  localparam int DEFAULT_DEPTH = 16;

  localparam logic [7:0] OPC_HLT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program memory: synchronous write port, combinational read port, never reset.
module cpu_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Byte write from the load interface.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: loads a program into local memory, then streams one byte
// per cycle to a valid/ready consumer with branch redirect and halt opcode.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW,
  parameter int DW    = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic [AW:0]   load_count,
  input  logic          run,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          halted
);

  localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PC_C = AW'(DEPTH - 1);
  localparam logic [DW-1:0] HLT_C     = DW'(OPC_HLT);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] ipc_q, ipc_d;

  logic          mem_we_s;
  logic [AW-1:0] rd_addr_s;
  logic [DW-1:0] rd_data_s;

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return (pc == LAST_PC_C) ? '0 : pc + 1'b1;
  endfunction

  assign load_ready = (state_q == ST_LOAD) && (cnt_q < FULL_C);
  // rst gating keeps a reset edge from landing a byte in memory.
  assign mem_we_s   = load_ready && load_valid && !rst;
  assign rd_addr_s  = br_taken ? br_target : pc_q;

  cpu_prog_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (wp_q),
    .wdata_i (load_data),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    if (mem_we_s) begin
      wp_d  = wp_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end else begin
      wp_d  = wp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (br_taken) begin
          instr_d = rd_data_s;
          ipc_d   = br_target;
          valid_d = 1'b1;
          pc_d    = pc_inc(br_target);
        end else if (valid_q && instr_ready && (instr_q == HLT_C)) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (!valid_q || instr_ready) begin
          instr_d = rd_data_s;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc(pc_q);
        end else begin
          valid_d = valid_q;
        end
      end
      ST_HALT: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Load request overrides everything else; counters restart on entry.
    if (load_en) begin
      state_d = ST_LOAD;
      valid_d = 1'b0;
      if (state_q != ST_LOAD) begin
        wp_d  = '0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign load_count  = cnt_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: stimulus pushes expected (pc, instr) pairs,
// a negedge monitor pops and compares on every non-redirected handshake.
module tb_cpu_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic [4:0] load_count;
  logic       run = 1'b0;
  logic       instr_valid;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_ready = 1'b0;
  logic       br_taken = 1'b0;
  logic [3:0] br_target = 4'd0;
  logic       halted;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  cpu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .run         (run),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Monitor: consumed, non-redirected instructions are checked against the queue.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !br_taken) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_unexpected: got pc=%0d instr=0x%02h, required no delivery", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.ins) begin
          n_fail++;
          $display("FAIL fetch: got pc=%0d instr=0x%02h, required pc=%0d instr=0x%02h",
                   instr_pc, instr, e.pc, e.ins);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc, input int val);
    exp_t e;
    e.pc  = 4'(pc);
    e.ins = 8'(val);
    exp_q.push_back(e);
  endtask

  // Wait until every expected instruction was delivered, then stall the consumer.
  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    instr_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_run();
    run = 1'b0;
    instr_ready = 1'b0;
    step();
    run = 1'b1;
  endtask

  // Loads nbytes bytes: 0x10+i, except 0xFF at address 3 when hlt is set; byte 16 is 0xAA.
  task automatic load_image(input int nbytes, input bit hlt);
    run = 1'b0;
    load_en = 1'b1;
    load_valid = 1'b0;
    step();
    @(negedge clk);
    chk("load_entry_count", 32'(load_count), 32'd0);
    chk("load_entry_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      load_data  = (i == 16) ? 8'hAA : ((hlt && i == 3) ? 8'hFF : 8'(8'h10 + i));
      load_valid = 1'b1;
      step();
      @(negedge clk);
      chk("load_count", 32'(load_count), 32'((i < 16) ? i + 1 : 16));
      chk("load_ready", 32'(load_ready), 32'((i + 1 < 16) ? 1 : 0));
    end
    load_valid = 1'b0;
    load_en = 1'b0;
    step();
    @(negedge clk);
    chk("idle_load_ready", 32'(load_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    step();
    rst = 1'b0;

    // 17 bytes: the last one must be dropped, leaving mem[0] = 0x10.
    load_image(17, 1'b0);

    // Full sweep then wrap.
    start_run();
    for (int i = 0; i < 16; i++) push(i, 8'h10 + i);
    for (int i = 0; i < 4; i++) push(i, 8'h10 + i);
    instr_ready = 1'b1;
    drain();

    // Back-pressure at pc 2.
    start_run();
    push(0, 8'h10);
    push(1, 8'h11);
    instr_ready = 1'b1;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", 32'(instr_pc), 32'd2);
      chk("stall_instr", 32'(instr), 32'h12);
      step();
    end
    push(2, 8'h12);
    push(3, 8'h13);
    instr_ready = 1'b1;
    drain();

    // Redirect to 9 while pc 4 is presented.
    @(negedge clk);
    chk("pre_branch_pc", 32'(instr_pc), 32'd4);
    step();
    instr_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 4'd9;
    push(9, 8'h19);
    push(10, 8'h1A);
    step();
    br_taken = 1'b0;
    drain();

    // Halt opcode at address 3.
    load_image(16, 1'b1);
    start_run();
    for (int i = 0; i < 3; i++) push(i, 8'h10 + i);
    push(3, 8'hFF);
    instr_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    chk("halt_hold", 32'(halted), 32'd1);

    // Redirect in the same cycle as the HLT handshake wins.
    start_run();
    @(negedge clk);
    chk("rerun_not_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) push(i, 8'h10 + i);
    instr_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("hlt_presented", 32'(instr), 32'hFF);
    step();
    instr_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 4'd0;
    push(0, 8'h10);
    push(1, 8'h11);
    step();
    br_taken = 1'b0;
    drain();
    @(negedge clk);
    chk("br_hlt_no_halt", 32'(halted), 32'd0);
    chk("br_hlt_valid", 32'(instr_valid), 32'd1);
    chk("br_hlt_pc", 32'(instr_pc), 32'd2);

    // Asynchronous reset mid-run at pc 6.
    step();
    instr_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 4'd4;
    push(4, 8'h14);
    push(5, 8'h15);
    step();
    br_taken = 1'b0;
    drain();
    @(negedge clk);
    chk("pre_rst_pc", 32'(instr_pc), 32'd6);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);
    chk("mid_rst_pc", 32'(instr_pc), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
    run = 1'b0;
    step();
    rst = 1'b0;
    start_run();
    for (int i = 0; i < 3; i++) push(i, 8'h10 + i);
    push(3, 8'hFF);
    instr_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("post_rst_halted", 32'(halted), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
